// File: rtl/nx_stream_distributor.sv
// Routes an inbound message stream into four per-direction FIFOs.
// Each outbound stream drains independently under its own valid/ready handshake.
package nx_pkg;
  typedef logic [31:0] nx_message_t;
  typedef enum logic [1:0] {
    NORTH = 2'd0,
    EAST  = 2'd1,
    SOUTH = 2'd2,
    WEST  = 2'd3
  } nx_direction_t;
endpackage

module nx_stream_distributor
  import nx_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  nx_message_t   dist_data_i,
  input  nx_direction_t dist_dir_i,
  input  logic          dist_valid_i,
  output logic          dist_ready_o,
  output nx_message_t   north_data_o,
  output logic          north_valid_o,
  input  logic          north_ready_i,
  output nx_message_t   east_data_o,
  output logic          east_valid_o,
  input  logic          east_ready_i,
  output nx_message_t   south_data_o,
  output logic          south_valid_o,
  input  logic          south_ready_i,
  output nx_message_t   west_data_o,
  output logic          west_valid_o,
  input  logic          west_ready_i,
  output logic          idle_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q [4];
  logic [PW-1:0] wr_ptr_d [4];
  logic [PW-1:0] rd_ptr_q [4];
  logic [PW-1:0] rd_ptr_d [4];
  logic [CW-1:0] cnt_q    [4];
  logic [CW-1:0] cnt_d    [4];
  nx_message_t   mem_q    [4][FIFO_DEPTH];
  nx_message_t   head     [4];

  logic [3:0] empty;
  logic [3:0] full;
  logic [3:0] dir_oh;
  logic [3:0] push;
  logic [3:0] pop;
  logic [3:0] out_rdy;

  assign out_rdy = {west_ready_i, south_ready_i, east_ready_i, north_ready_i};
  assign dir_oh  = 4'b0001 << dist_dir_i;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int d = 0; d < 4; d++) begin
      empty[d] = (cnt_q[d] == '0);
      full[d]  = (cnt_q[d] == CW'(FIFO_DEPTH));
    end
  end

  // Inbound acceptance looks only at registered occupancy, never at outbound ready
  assign dist_ready_o = ~full[dist_dir_i];
  assign push         = {4{dist_valid_i & dist_ready_o}} & dir_oh;
  assign pop          = ~empty & out_rdy;

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      wr_ptr_d[d] = wr_ptr_q[d];
      rd_ptr_d[d] = rd_ptr_q[d];
      cnt_d[d]    = cnt_q[d];
      if (push[d]) wr_ptr_d[d] = wr_ptr_q[d] + PW'(1);
      if (pop[d])  rd_ptr_d[d] = rd_ptr_q[d] + PW'(1);
      case ({push[d], pop[d]})
        2'b10:   cnt_d[d] = cnt_q[d] + CW'(1);
        2'b01:   cnt_d[d] = cnt_q[d] - CW'(1);
        default: cnt_d[d] = cnt_q[d];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int d = 0; d < 4; d++) begin
        wr_ptr_q[d] <= '0;
        rd_ptr_q[d] <= '0;
        cnt_q[d]    <= '0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        wr_ptr_q[d] <= wr_ptr_d[d];
        rd_ptr_q[d] <= rd_ptr_d[d];
        cnt_q[d]    <= cnt_d[d];
      end
    end
  end

  // Storage is not reset; empty queues mask their head to zero instead
  always_ff @(posedge clk_i) begin
    for (int d = 0; d < 4; d++) begin
      if (push[d]) mem_q[d][wr_ptr_q[d]] <= dist_data_i;
    end
  end

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      head[d] = empty[d] ? '0 : mem_q[d][rd_ptr_q[d]];
    end
  end

  assign north_data_o  = head[0];
  assign east_data_o   = head[1];
  assign south_data_o  = head[2];
  assign west_data_o   = head[3];
  assign north_valid_o = ~empty[0];
  assign east_valid_o  = ~empty[1];
  assign south_valid_o = ~empty[2];
  assign west_valid_o  = ~empty[3];
  assign idle_o        = &empty;

endmodule

// File: doc/nx_stream_distributor.md
NX_STREAM_DISTRIBUTOR -- requirements
Module: nx_stream_distributor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning entries per outbound direction queue; legal values are powers of two, 2 or greater.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port dist_data_i, input, nx_message_t: inbound message, the bypass stream from the arbiter.
REQ-005 SHALL have port dist_dir_i, input, nx_direction_t: target direction (NORTH=0, EAST=1, SOUTH=2, WEST=3).
REQ-006 SHALL have port dist_valid_i, input, 1 bit, and port dist_ready_o, output, 1 bit: inbound handshake.
REQ-007 SHALL have, for each D in {north, east, south, west}, ports D_data_o (output, nx_message_t), D_valid_o (output, 1 bit) and D_ready_i (input, 1 bit): the outbound stream for D.
REQ-008 SHALL have port idle_o, output, 1 bit: high when all four queues are empty.

Function
REQ-009 SHALL hold one FIFO_DEPTH-entry FIFO per direction; each FIFO has read/write pointers of width $clog2(FIFO_DEPTH) that wrap modulo FIFO_DEPTH, and a count of width $clog2(FIFO_DEPTH)+1.
REQ-010 SHALL drive dist_ready_o high exactly when the FIFO selected by dist_dir_i is not full, as a function of registered state and dist_dir_i only; it never depends on any D_ready_i.
REQ-011 SHALL push dist_data_i into the FIFO selected by dist_dir_i on a clock edge where dist_valid_i && dist_ready_o; in that cycle it pushes no other FIFO.
REQ-012 SHALL drive D_valid_o high exactly when FIFO D is non-empty, with D_data_o equal to the head entry of FIFO D.
REQ-013 SHALL pop FIFO D on a clock edge where D_valid_o && D_ready_i.
REQ-014 SHALL present a message pushed at edge N on D_valid_o/D_data_o from cycle N+1: one cycle of latency, no combinational bypass.
REQ-015 SHALL preserve per-direction order and never drop or duplicate a message; it imposes no ordering across directions.
REQ-016 SHALL keep D_data_o stable and D_valid_o high while D_valid_o is high and D_ready_i is low.
REQ-017 SHALL allow a push and a pop on the same FIFO in one cycle when it is neither empty nor full: count unchanged, both pointers advance.
REQ-018 SHALL, with an empty FIFO and a simultaneous push, not pop, since valid is low that cycle; count becomes 1.
REQ-019 SHALL hold dist_ready_o low for that direction while its FIFO is full, even if D_ready_i is high in the same cycle; the push is retried the next cycle after the pop frees space.
REQ-020 SHALL let the four outputs drain independently and concurrently; pops on all four FIFOs in one cycle are legal.
REQ-021 SHALL drive idle_o high exactly when all four counts are zero, from registered state.

Reset
REQ-022 SHALL, at a clock edge with rst_i high, clear every pointer and count to 0, so that in the next cycle all D_valid_o are 0, all D_data_o are 0, idle_o is 1, and dist_ready_o is 1.
REQ-023 SHALL, on reset asserted mid-operation, discard all queued messages and ignore any handshake coincident with that edge.
REQ-024 SHALL leave FIFO storage contents unspecified after reset; data outputs are masked to 0 while empty.

Verification
REQ-025 SHALL cover: after reset, push A (dir EAST) at edge 1 -> east_valid_o=1 with data A in cycle 2, other valids 0, idle_o=0.
REQ-026 SHALL cover: with FIFO_DEPTH=2 and north_ready_i=0, push N1, N2 -> dist_ready_o=0 while dir=NORTH and 1 while dir=SOUTH; a push of S1 succeeds; raising north_ready_i pops N1 then N2 in order.
REQ-027 SHALL cover: a full NORTH FIFO with north_ready_i=1 and a push offered to NORTH -> the push is refused that cycle and accepted the next; no loss, order N1, N2, N3.
REQ-028 SHALL cover: a count=1 FIFO with push and pop in the same cycle -> count remains 1 and the output changes to the new message next cycle.
REQ-029 SHALL cover: all four FIFOs holding 1 entry and all D_ready_i=1 -> all four drain in one cycle and idle_o=1 the next cycle.
REQ-030 SHALL cover: rst_i pulsed for 1 cycle while holding 5 messages and a push is in flight -> all valids are 0 and idle_o=1 the next cycle, and the in-flight message is never output.
